// File: rtl/wdog_pkg.sv
// wdog_pkg
// Shared definitions for the AHB-Lite watchdog: register offsets (word index
// taken from haddr[4:2]), the LOCK unlock key, CTRL bit positions and the
// HTRANS encodings used to qualify an address phase.
package wdog_pkg;

  typedef enum logic [2:0] {
    OFF_LOAD   = 3'd0,
    OFF_VALUE  = 3'd1,
    OFF_CTRL   = 3'd2,
    OFF_INTCLR = 3'd3,
    OFF_RIS    = 3'd4,
    OFF_LOCK   = 3'd5
  } reg_off_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [31:0] LOCK_KEY = 32'h1ACCE551;

  localparam int CTRL_INTEN = 0;
  localparam int CTRL_RESEN = 1;

  // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY are ignored.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/wdog_counter.sv
// wdog_counter
// Timing core of the watchdog: prescaler, 32-bit down-counter, raw interrupt
// status and the fixed-length reset request pulse.
//
// Ports:
//   sys_clk, sys_rst  clock, asynchronous active-high reset
//   reload            load value <= load_val and clear the prescaler
//   load_val          value used for any reload, including expiry
//   inten             enables counting (prescaler and counter hold when 0)
//   resen             allows a reset pulse on an expiry with RIS already set
//   clr_ris           clears the raw interrupt status
//   value             current counter value
//   ris               raw interrupt status
//   rst_req           reset request, high for RST_PULSE cycles
module wdog_counter #(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RST_PULSE = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        reload,
  input  logic [31:0] load_val,
  input  logic        inten,
  input  logic        resen,
  input  logic        clr_ris,
  output logic [31:0] value,
  output logic        ris,
  output logic        rst_req
);

  logic [31:0] presc_q, presc_d;
  logic [31:0] value_q, value_d;
  logic [31:0] pulse_q, pulse_d;
  logic        ris_q, ris_d;
  logic        tick;
  logic        pulse_active;

  // A register-driven reload always beats the tick in the same cycle, so a
  // LOAD/INTCLR write colliding with expiry neither sets RIS nor pulses.
  // The pulse counter runs down independently and is never retriggered
  // while still non-zero.
  always_comb begin
    tick         = inten && (presc_q == PRESCALE - 1);
    pulse_active = (pulse_q != 32'd0);
    presc_d      = presc_q;
    value_d      = value_q;
    ris_d        = ris_q;
    pulse_d      = pulse_active ? (pulse_q - 32'd1) : pulse_q;

    if (inten) begin
      presc_d = tick ? 32'd0 : (presc_q + 32'd1);
    end

    if (clr_ris) begin
      ris_d = 1'b0;
    end

    if (reload) begin
      value_d = load_val;
      presc_d = 32'd0;
    end else if (tick) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else begin
        value_d = load_val;
        if (ris_q && resen && !pulse_active) begin
          pulse_d = RST_PULSE;
        end
        ris_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc_q <= 32'd0;
      value_q <= 32'hFFFF_FFFF;
      pulse_q <= 32'd0;
      ris_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      value_q <= value_d;
      pulse_q <= pulse_d;
      ris_q   <= ris_d;
    end
  end

  assign value   = value_q;
  assign ris     = ris_q;
  assign rst_req = pulse_active;

endmodule

// File: rtl/ahb_watchdog.sv
// ahb_watchdog
// AHB-Lite slave register interface for the watchdog timer. Zero wait-state:
// the address phase is registered and read data is driven combinationally
// from it during the data phase; writes land on the edge ending the data
// phase.
//
// Ports:
//   sys_clk, sys_rst   clock, asynchronous active-high reset
//   hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in   AHB-Lite inputs
//   hrdata, hready, hresp                                   AHB-Lite outputs
//   wdog_int           interrupt level (RIS masked by INTEN), to nmi_req
//   wdog_rst_req       reset request pulse, to watchdog_reset
module ahb_watchdog
  import wdog_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned RST_PULSE = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic        wdog_int,
  output logic        wdog_rst_req
);

  logic [2:0]  addr_q;
  logic        write_q;
  logic        valid_q;
  logic [31:0] load_q;
  logic [1:0]  ctrl_q;
  logic        lock_q;

  logic        wr_en;
  logic        wr_load;
  logic        wr_ctrl;
  logic        wr_intclr;
  logic        wr_lock;
  logic        reload;
  logic        resen_eff;
  logic [31:0] load_val;
  logic [31:0] value;
  logic        ris;
  logic        unused_bits;

  assign unused_bits = ^{haddr[31:5], haddr[1:0], hsize};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_q  <= 3'd0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= hsel && hready_in && is_active_trans(htrans);
      addr_q  <= haddr[4:2];
      write_q <= hwrite;
    end
  end

  assign wr_en     = valid_q && write_q;
  assign wr_load   = wr_en && (addr_q == OFF_LOAD)   && !lock_q;
  assign wr_ctrl   = wr_en && (addr_q == OFF_CTRL)   && !lock_q;
  assign wr_intclr = wr_en && (addr_q == OFF_INTCLR) && !lock_q;
  assign wr_lock   = wr_en && (addr_q == OFF_LOCK);

  // A LOAD write reloads with the value being written, not the old LOAD.
  // The RESEN seen by the counter follows a CTRL write in the same cycle so
  // that clearing RESEN on the expiry edge suppresses the pulse.
  assign reload    = wr_load || wr_intclr ||
                     (wr_ctrl && !ctrl_q[CTRL_INTEN] && hwdata[CTRL_INTEN]);
  assign load_val  = wr_load ? hwdata : load_q;
  assign resen_eff = wr_ctrl ? hwdata[CTRL_RESEN] : ctrl_q[CTRL_RESEN];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      load_q <= 32'hFFFF_FFFF;
      ctrl_q <= 2'b00;
      lock_q <= 1'b0;
    end else begin
      if (wr_load) begin
        load_q <= hwdata;
      end
      if (wr_ctrl) begin
        ctrl_q <= {hwdata[CTRL_RESEN], hwdata[CTRL_INTEN]};
      end
      if (wr_lock) begin
        lock_q <= (hwdata != LOCK_KEY);
      end
    end
  end

  wdog_counter #(
    .PRESCALE  (PRESCALE),
    .RST_PULSE (RST_PULSE)
  ) u_counter (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .reload   (reload),
    .load_val (load_val),
    .inten    (ctrl_q[CTRL_INTEN]),
    .resen    (resen_eff),
    .clr_ris  (wr_intclr),
    .value    (value),
    .ris      (ris),
    .rst_req  (wdog_rst_req)
  );

  // Outside a read data phase the bus sees zero, which also gives the
  // required reset value.
  always_comb begin
    hrdata = 32'd0;
    if (valid_q && !write_q) begin
      case (addr_q)
        OFF_LOAD:  hrdata = load_q;
        OFF_VALUE: hrdata = value;
        OFF_CTRL:  hrdata = {30'd0, ctrl_q};
        OFF_RIS:   hrdata = {31'd0, ris};
        OFF_LOCK:  hrdata = {31'd0, lock_q};
        default:   hrdata = 32'd0;
      endcase
    end
  end

  assign hready   = 1'b1;
  assign hresp    = 1'b0;
  assign wdog_int = ris && ctrl_q[CTRL_INTEN];

endmodule
